// File: rtl/hazard_control_unit.sv
// ID-stage hazard sequencer: EX/MEM/WB destination scoreboard, issue/stall/flush, EX operand forward selects.
// Define HCU_FORWARDING_EN for the forwarding build; the default build stalls until the producer reaches WB.
module hazard_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             flush_if,
  output logic             issue,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [6:0] OP_R      = 7'b0000000;
  localparam logic [6:0] OP_LOAD   = 7'b0100011;
  localparam logic [6:0] OP_STORE  = 7'b0101011;
  localparam logic [6:0] OP_BRANCH = 7'b0000100;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       writes;
    logic       is_load;
  } slot_t;

  slot_t sb_ex, sb_mem, sb_wb, id_slot;
  logic  use1, use2;
  logic  ex_a, ex_b, mem_a, mem_b;
  logic  hazard;

  function automatic logic slot_match(input slot_t s, input logic [4:0] src);
    return s.valid & s.writes & (s.rd == src);
  endfunction

  always_comb begin
    use1            = 1'b0;
    use2            = 1'b0;
    id_slot         = '0;
    id_slot.valid   = 1'b1;
    id_slot.rd      = id_rd;
    case (id_opcode)
      OP_R: begin
        use1           = 1'b1;
        use2           = 1'b1;
        id_slot.writes = 1'b1;
      end
      OP_LOAD: begin
        use1            = 1'b1;
        id_slot.writes  = 1'b1;
        id_slot.is_load = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      default: ;
    endcase
    // x0 is hardwired: never a real source or destination
    if (id_rd == 5'd0) id_slot.writes = 1'b0;
    if (id_rs1 == 5'd0) use1 = 1'b0;
    if (id_rs2 == 5'd0) use2 = 1'b0;
  end

  assign ex_a  = use1 & slot_match(sb_ex, id_rs1);
  assign ex_b  = use2 & slot_match(sb_ex, id_rs2);
  assign mem_a = use1 & slot_match(sb_mem, id_rs1);
  assign mem_b = use2 & slot_match(sb_mem, id_rs2);

`ifdef HCU_FORWARDING_EN
  assign hazard = id_valid & sb_ex.is_load & (ex_a | ex_b);
`else
  assign hazard = id_valid & (ex_a | ex_b | mem_a | mem_b);
`endif

  always_comb begin
    flush_if = ex_branch_taken;
    stall    = ~ex_branch_taken & hazard;
    issue    = ~ex_branch_taken & ~hazard & id_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_ex       <= '0;
      sb_mem      <= '0;
      sb_wb       <= '0;
      stall_count <= '0;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= issue ? id_slot : '0;
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

`ifdef HCU_FORWARDING_EN
  logic [1:0] sel_a, sel_b;

  assign sel_a = ex_a ? 2'b01 : (mem_a ? 2'b10 : 2'b00);
  assign sel_b = ex_b ? 2'b01 : (mem_b ? 2'b10 : 2'b00);

  always_ff @(posedge clk) begin
    if (reset || !issue) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else begin
      fwd_a <= sel_a;
      fwd_b <= sel_b;
    end
  end
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  // WB slot only tracks retirement; the regfile is write-before-read so it never gates issue
  logic unused_sb;
  assign unused_sb = ^{sb_wb, sb_mem.is_load, sb_ex.is_load};

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit; expectations follow HCU_FORWARDING_EN when it is defined.
module tb_hazard_control_unit;

  localparam int CW = 4;
`ifdef HCU_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [6:0] OP_R   = 7'b0000000;
  localparam logic [6:0] OP_LD  = 7'b0100011;
  localparam logic [6:0] OP_ST  = 7'b0101011;
  localparam logic [6:0] OP_NOP = 7'b0010011;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [6:0]    id_opcode;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          ex_branch_taken;
  logic          stall, flush_if, issue;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;
  int sat_sum = 0;

  hazard_control_unit #(.CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .id_valid(id_valid),
    .id_opcode(id_opcode),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken),
    .stall(stall),
    .flush_if(flush_if),
    .issue(issue),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold one instruction in ID until it issues; returns the number of stall cycles seen.
  task automatic send(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, output int n_stall);
    logic issued;
    n_stall = 0;
    issued  = 1'b0;
    id_valid = 1'b1; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    for (int i = 0; i < 8 && !issued; i++) begin
      #1;
      if (issue) issued = 1'b1;
      else if (stall) n_stall++;
      @(posedge clk);
      #1;
    end
    id_valid = 1'b0; id_opcode = OP_NOP;
    check("issue_timeout", 16'(issued), 16'd1);
  endtask

  task automatic nop_cycle();
    id_valid = 1'b1; id_opcode = OP_NOP; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    @(posedge clk);
    #1;
    id_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_opcode = OP_NOP;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; ex_branch_taken = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flush_follows_branch", 16'(flush_if), 16'd1);
    check("rst_stall", 16'(stall), 16'd0);
    check("rst_issue", 16'(issue), 16'd0);
    check("rst_fwd_a", 16'(fwd_a), 16'd0);
    check("rst_fwd_b", 16'(fwd_b), 16'd0);
    check("rst_count", 16'(stall_count), 16'd0);
    ex_branch_taken = 1'b0;
    #1;
    check("rst_flush_low", 16'(flush_if), 16'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // back-to-back R/R dependence on x3
    send(OP_R, 5'd1, 5'd2, 5'd3, n);
    check("prod_stalls", 16'(n), 16'd0);
    check("prod_fwd_a", 16'(fwd_a), 16'd0);
    send(OP_R, 5'd3, 5'd5, 5'd4, n);
    check("b2b_stalls", 16'(n), FWD ? 16'd0 : 16'd2);
    check("b2b_fwd_a", 16'(fwd_a), FWD ? 16'd1 : 16'd0);
    check("b2b_fwd_b", 16'(fwd_b), 16'd0);
    check("b2b_count", 16'(stall_count), FWD ? 16'd0 : 16'd2);

    // distance-2 dependence
    send(OP_R, 5'd1, 5'd2, 5'd3, n);
    nop_cycle();
    send(OP_R, 5'd3, 5'd5, 5'd4, n);
    check("d2_stalls", 16'(n), FWD ? 16'd0 : 16'd1);
    check("d2_fwd_a", 16'(fwd_a), FWD ? 16'd2 : 16'd0);

    // distance-3 dependence: regfile covers it
    send(OP_R, 5'd1, 5'd2, 5'd3, n);
    nop_cycle();
    nop_cycle();
    send(OP_R, 5'd3, 5'd5, 5'd4, n);
    check("d3_stalls", 16'(n), 16'd0);
    check("d3_fwd_a", 16'(fwd_a), 16'd0);

    // load-use
    send(OP_LD, 5'd1, 5'd0, 5'd6, n);
    send(OP_R, 5'd6, 5'd1, 5'd7, n);
    check("lu_stalls", 16'(n), FWD ? 16'd1 : 16'd2);
    check("lu_fwd_a", 16'(fwd_a), FWD ? 16'd2 : 16'd0);
    check("lu_count", 16'(stall_count), FWD ? 16'd1 : 16'd5);

    // load-use coincident with a taken branch: flush wins, nothing counted
    send(OP_LD, 5'd1, 5'd0, 5'd8, n);
    id_valid = 1'b1; id_opcode = OP_R; id_rs1 = 5'd8; id_rs2 = 5'd0; id_rd = 5'd9;
    ex_branch_taken = 1'b1;
    #1;
    check("br_flush", 16'(flush_if), 16'd1);
    check("br_stall", 16'(stall), 16'd0);
    check("br_issue", 16'(issue), 16'd0);
    @(posedge clk);
    #1;
    ex_branch_taken = 1'b0; id_valid = 1'b0;
    check("br_count", 16'(stall_count), FWD ? 16'd1 : 16'd5);
    repeat (2) @(posedge clk);
    #1;

    // x0 producer never creates a dependence
    send(OP_R, 5'd1, 5'd2, 5'd0, n);
    send(OP_R, 5'd0, 5'd0, 5'd10, n);
    check("x0_stalls", 16'(n), 16'd0);
    check("x0_fwd_a", 16'(fwd_a), 16'd0);

    // store reading the producer through rs2
    send(OP_R, 5'd1, 5'd2, 5'd12, n);
    send(OP_ST, 5'd13, 5'd12, 5'd20, n);
    check("st_stalls", 16'(n), FWD ? 16'd0 : 16'd2);
    check("st_fwd_a", 16'(fwd_a), 16'd0);
    check("st_fwd_b", 16'(fwd_b), FWD ? 16'd1 : 16'd0);
    check("st_count", 16'(stall_count), FWD ? 16'd1 : 16'd7);
    // the store's rd field must not be recorded as a write
    send(OP_R, 5'd20, 5'd0, 5'd21, n);
    check("st_nowrite_stalls", 16'(n), 16'd0);
    check("st_nowrite_fwd_a", 16'(fwd_a), 16'd0);

    // saturation: at least 2^CW+3 stall cycles through a dependent load chain
    for (int i = 0; i < 40 && sat_sum < (2**CW + 3); i++) begin
      send(OP_LD, 5'd16, 5'd0, 5'd16, n);
      sat_sum += n;
    end
    check("sat_count", 16'(stall_count), 16'(2**CW - 1));
    check("sat_last_fwd_a", 16'(fwd_a), FWD ? 16'd2 : 16'd0);

    // reset asserted in the middle of a load-use stall
    id_valid = 1'b1; id_opcode = OP_R; id_rs1 = 5'd16; id_rs2 = 5'd0; id_rd = 5'd18;
    #1;
    check("mid_stall_pre", 16'(stall), 16'd1);
    check("mid_fwd_a_pre", 16'(fwd_a), FWD ? 16'd2 : 16'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_stall", 16'(stall), 16'd0);
    check("mid_rst_issue", 16'(issue), 16'd1);
    check("mid_rst_count", 16'(stall_count), 16'd0);
    check("mid_rst_fwd_a", 16'(fwd_a), 16'd0);
    check("mid_rst_fwd_b", 16'(fwd_b), 16'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    id_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- ID-stage sequencer for the 5-stage pipeline. It consumes the instruction decoder's opcode/rs1/rs2/rd fields each cycle.
- Tracks in-flight destination registers for EX, MEM and WB in an internal stage scoreboard.
- Decides whether the ID instruction issues, stalls or is squashed, and produces registered forwarding selects for the EX-stage ALU operand muxes.
- Counts stall cycles for performance debug.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- id_valid  input  1  ID/IF register holds a real instruction
- id_opcode  input  7  decoder opcode field
- id_rs1  input  5  decoder read_reg1
- id_rs2  input  5  decoder read_reg2
- id_rd  input  5  decoder write_reg
- ex_branch_taken  input  1  branch in EX resolved taken this cycle
- stall  output  1  hold PC and IF/ID register (combinational)
- flush_if  output  1  squash IF/ID contents (combinational)
- issue  output  1  ID instruction enters EX at next edge (combinational)
- fwd_a  output  2  operand A select for the instruction now in EX: 00 regfile, 01 EX/MEM, 10 MEM/WB (registered)
- fwd_b  output  2  operand B select, same encoding (registered)
- stall_count  output  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Opcode classes:
  - R-type 0000000: reads rs1 and rs2; writes rd.
  - Load 0100011: reads rs1; writes rd.
  - Store 0101011: reads rs1 and rs2; no write.
  - Branch 0000100: reads rs1 and rs2; no write.
  - Any other opcode: NOP; no reads, no write; always issues when no branch flush.
- Register x0: a source or destination equal to 0 never creates a dependence. A writer with rd=0 is recorded as non-writing.
- Scoreboard: three slots, EX, MEM and WB. Each slot holds {valid, rd, writes, is_load}.
  - Every edge: WB<=MEM, MEM<=EX.
  - EX<=ID fields if issue=1, else EX<=bubble (valid=0).
  - The backend never stalls.
- Match definition: a slot matches a source register if slot.valid & slot.writes & slot.rd==src & src!=0.
- Register file is write-before-read, so a WB-slot match never needs forwarding or stalling.
- Hazard, forwarding build (FWD_EN defined):
  - hazard = id_valid & (an EX slot with is_load=1 matches a used source).
  - Load-use costs exactly 1 stall cycle.
- Hazard, no-forwarding build: see Optional Feature.
- Priority (highest first):
  - ex_branch_taken=1: flush_if=1, stall=0, issue=0; a bubble enters EX.
  - Else hazard=1: stall=1, issue=0, flush_if=0; a bubble enters EX.
  - Else: issue=id_valid, stall=0, flush_if=0.
- Forwarding selects:
  - Computed in ID per used source. An EX-slot match gives 01; else a MEM-slot match gives 10; else 00. The EX match wins when both slots match.
  - An unused source gives 00.
  - Registered on the edge where issue=1. On any non-issue edge the registered value is 00.
  - Latency: a select applies in the cycle the consumer is in EX, 1 cycle after ID.
- stall_count: increments by 1 on each edge with stall=1. Saturates at all-ones (no wrap). Flush cycles are not counted.
- Reset:
  - All slots invalid; fwd_a=fwd_b=00; stall_count=0.
  - The combinational outputs then follow the empty scoreboard: stall=0, flush_if=ex_branch_taken.
  - Reset asserted mid-stall drops the stall on the next cycle. The pending ID instruction is re-evaluated against the empty scoreboard.

Optional Feature:
- Macro: HCU_FORWARDING_EN
- Defined: forwarding as specified above. fwd_a/fwd_b are live; only load-use stalls.
- Undefined:
  - fwd_a=fwd_b=00 permanently.
  - hazard = id_valid & (an EX or MEM slot matches a used source).
  - A dependent instruction stalls until its producer reaches WB: 2 cycles for a back-to-back dependence, 1 cycle for a distance-2 dependence.
  - Load class is not special-cased.

Test Plan:
- R x3=x1+x2, then R x4=x3+x5 back-to-back (FWD on) -> no stall; fwd_a=01 in the consumer's EX cycle. With a one-NOP gap -> fwd_a=10. With a two-NOP gap -> 00.
- Load x6, then R x7=x6+x1 (FWD on) -> stall=1 for exactly 1 cycle; a bubble enters EX; then issue with fwd_a=10; stall_count=1.
- Same R/R pair (FWD off) -> stall=1 for 2 cycles; fwd_a stays 00; stall_count=2.
- Load-use stall coincident with ex_branch_taken=1 -> flush_if=1, stall=0, issue=0, stall_count unchanged.
- Producer rd=0, consumer rs1=0 -> no stall, fwd_a=00. Consumer is a store using rs2=producer rd -> fwd_b=01, fwd_a=00.
- Force 2^CNT_W+3 stall cycles -> stall_count holds all-ones. Assert reset mid-stall -> next cycle stall_count=0, stall=0, fwd=00.
